// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: EX-stage request/result bundle between the pipeline and the M-extension sequencer.
interface mdu_sequencer_if #(parameter int XLEN = 32);
  logic            START;
  logic [5:0]      ALU_SIGNAL;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            FLUSH;
  logic            STALL;
  logic [XLEN-1:0] RESULT;
  logic            RESULT_VALID;
  modport master (output START, ALU_SIGNAL, DATA1, DATA2, FLUSH, input STALL, RESULT, RESULT_VALID);
  modport slave (input START, ALU_SIGNAL, DATA1, DATA2, FLUSH, output STALL, RESULT, RESULT_VALID);
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M unit; shift-add multiply and restoring divide share one
// 2*XLEN accumulator (high half = partial product / remainder, low half = multiplier / quotient).
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic CLK,
  input logic RESET,
  mdu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op, f;
  logic              sign1, sign2, s1, s2, req, accept, div_zero, ovf, unused_bits;
  logic [XLEN-1:0]   mag2, m1, m2, fast, quo, rem, fix_res;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN:0]     msum, rsh, rdiff;
  always_comb begin
    unused_bits = bus.ALU_SIGNAL[5];
    f = bus.ALU_SIGNAL[2:0];
    req = bus.START & bus.ALU_SIGNAL[3] & ~bus.ALU_SIGNAL[4];
    // The cycle carrying RESULT_VALID is the hand-back cycle: nothing is accepted and the pipeline runs
    accept = (state == IDLE) & req & ~bus.RESULT_VALID;
    bus.STALL = (state == IDLE) ? req & ~bus.RESULT_VALID : 1'b1;
    s1 = bus.DATA1[XLEN-1] & (f == 3'b001 | f == 3'b010 | f == 3'b100 | f == 3'b110);
    s2 = bus.DATA2[XLEN-1] & (f == 3'b001 | f == 3'b100 | f == 3'b110);
    m1 = s1 ? -bus.DATA1 : bus.DATA1;
    m2 = s2 ? -bus.DATA2 : bus.DATA2;
    div_zero = f[2] & (bus.DATA2 == '0);
    ovf = f[2] & ~f[0] & (bus.DATA1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.DATA2);
    fast = div_zero ? (f[1] ? bus.DATA1 : '1) : (f[1] ? '0 : bus.DATA1);
    msum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? mag2 : '0};
    rsh = acc[2*XLEN-1:XLEN-1];
    rdiff = rsh - {1'b0, mag2};
    prod = (sign1 ^ sign2) ? -acc : acc;
    quo = (sign1 ^ sign2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = sign1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res = op[2] ? (op[1] ? rem : quo) : (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      sign1 <= 1'b0;
      sign2 <= 1'b0;
      mag2 <= '0;
      acc <= '0;
      bus.RESULT <= '0;
      bus.RESULT_VALID <= 1'b0;
    end else if (bus.FLUSH) begin
      state <= IDLE;
      bus.RESULT_VALID <= 1'b0;
    end else begin
      bus.RESULT_VALID <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op <= f;
          sign1 <= s1;
          sign2 <= s2;
          mag2 <= m2;
          acc <= {{XLEN{1'b0}}, m1};
          cnt <= CNT_W'(XLEN - 1);
          if (div_zero | ovf) begin
            bus.RESULT <= fast;
            state <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          acc <= op[2] ? (rdiff[XLEN] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {rdiff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                       : {msum, acc[XLEN-1:1]};
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          bus.RESULT <= fix_res;
          state <= DONE;
        end
        DONE: begin
          bus.RESULT_VALID <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vector table plus flush, reset and hand-back sequences.
module tb_mdu_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  int errors = 0;
  int checks = 0;
  always #5 CLK = ~CLK;
  mdu_sequencer_if #(.XLEN(32)) bus ();
  mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vecs[19];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_valid(output int edges, output int stalls);
    edges = 0;
    stalls = 0;
    do begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (bus.STALL) stalls++;
    end while (!bus.RESULT_VALID && edges < 80);
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.ALU_SIGNAL = {3'b001, op};
    bus.DATA1 = d1;
    bus.DATA2 = d2;
    #1;
  endtask
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] res, input int lat);
    int edges, stalls, pre;
    issue(op, d1, d2);
    pre = bus.STALL ? 1 : 0;
    wait_valid(edges, stalls);
    check({name, " result"}, bus.RESULT, res);
    check({name, " latency"}, edges, lat);
    check({name, " stall cycles"}, stalls + pre, lat);
    bus.START = 1'b0;
  endtask
  initial begin
    int edges, stalls;
    logic seen;
    vecs[0]  = '{3'b000, 32'd7, 32'd6, 32'd42, 35};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 35};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35};
    vecs[6]  = '{3'b101, 32'd100, 32'd7, 32'd14, 35};
    vecs[7]  = '{3'b111, 32'd100, 32'd7, 32'd2, 35};
    vecs[8]  = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 2};
    vecs[9]  = '{3'b110, 32'd5, 32'd0, 32'd5, 2};
    vecs[10] = '{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 2};
    vecs[11] = '{3'b111, 32'd5, 32'd0, 32'd5, 2};
    vecs[12] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[13] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[14] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35};
    vecs[15] = '{3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 35};
    vecs[16] = '{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 35};
    vecs[17] = '{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 35};
    vecs[18] = '{3'b101, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 35};
    RESET = 1'b0;
    bus.START = 1'b0;
    bus.ALU_SIGNAL = '0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;
    bus.FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset result", bus.RESULT, 32'd0);
    check("reset valid", {31'd0, bus.RESULT_VALID}, 32'd0);
    check("reset stall", {31'd0, bus.STALL}, 32'd0);
    RESET = 1'b1;
    foreach (vecs[i]) begin
      @(negedge CLK);
      bus.START = 1'b1;
      bus.ALU_SIGNAL = i[0] ? 6'b010000 : 6'b011000;
      #1;
      check("non-M stall", {31'd0, bus.STALL}, 32'd0);
      bus.START = 1'b0;
      if (i == 1) break;
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | bus.RESULT_VALID | bus.STALL;
    end
    check("non-M no activity", {31'd0, seen}, 32'd0);
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].res, vecs[i].lat);
    @(negedge CLK);
    check("valid single pulse", {31'd0, bus.RESULT_VALID}, 32'd0);
    issue(3'b100, 32'd100, 32'd7);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    bus.FLUSH = 1'b1;
    bus.START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    bus.FLUSH = 1'b0;
    #1;
    check("flush stall", {31'd0, bus.STALL}, 32'd0);
    check("flush result held", bus.RESULT, 32'h7FFFFFFF);
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen = seen | bus.RESULT_VALID | bus.STALL;
    end
    check("flush no valid", {31'd0, seen}, 32'd0);
    run_op("after flush", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
    issue(3'b100, 32'd100, 32'd7);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    bus.START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("midop reset result", bus.RESULT, 32'd0);
    check("midop reset valid", {31'd0, bus.RESULT_VALID}, 32'd0);
    check("midop reset stall", {31'd0, bus.STALL}, 32'd0);
    RESET = 1'b1;
    run_op("after reset", 3'b101, 32'd100, 32'd7, 32'd14, 35);
    issue(3'b000, 32'd7, 32'd6);
    wait_valid(edges, stalls);
    check("held first result", bus.RESULT, 32'd42);
    check("held valid-cycle stall", {31'd0, bus.STALL}, 32'd0);
    wait_valid(edges, stalls);
    check("held re-accept latency", edges, 36);
    check("held second result", bus.RESULT, 32'd42);
    bus.START = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations flagged by the decoder (alu_signal[3]=1, alu_signal[4]=0; funct3 in alu_signal[2:0]).
- Sits beside the single-cycle ALU in the EX stage. It accepts an operation, holds the pipeline via a stall output, and iterates a shift-add multiplier or a restoring divider. It returns a result with a one-cycle valid pulse.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  EX stage holds a valid M-extension instruction.
- ALU_SIGNAL  input  6  decoded ALU control; [2:0] selects the op, [3] marks M-extension.
- DATA1  input  XLEN  rs1 operand.
- DATA2  input  XLEN  rs2 operand.
- FLUSH  input  1  pipeline flush; aborts any operation in progress.
- STALL  output  1  freezes PC and IF/ID/EX registers.
- RESULT  output  XLEN  operation result.
- RESULT_VALID  output  1  one-cycle pulse; RESULT is valid while high.

Behaviour:
- Op decode (funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A request is START & ALU_SIGNAL[3] & ~ALU_SIGNAL[4]. Anything else is ignored.
- Reset (RESET=0 at the edge): state=IDLE, counter=0, RESULT=0, RESULT_VALID=0, STALL=0, internal registers cleared. Reset overrides FLUSH and START, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - STALL = request (combinational).
  - On a request edge, latch the op, both signs and the operand magnitudes:
    - Signed operands: DIV, REM, MULH, and rs1 of MULHSU.
    - Unsigned operands: rs2 of MULHSU, MULHU, DIVU, REMU, MUL.
  - Load counter with XLEN-1.
  - Next state is CALC, or DONE on the fast path.
- Fast paths (IDLE to DONE directly, RESULT_VALID one edge after acceptance):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give DATA1.
  - Signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC:
  - STALL=1.
  - One iteration per cycle on a 2*XLEN product register or a remainder/quotient pair.
  - Counter decrements each cycle. Leave for FIX when counter==0, so CALC lasts exactly XLEN cycles.
- FIX:
  - STALL=1.
  - Negate results when the signs require it:
    - Product: sign1 ^ sign2.
    - Quotient: sign1 ^ sign2.
    - Remainder: takes the sign of the dividend.
  - Select the low word (MUL) or high word (MULH*), quotient or remainder. Register the selection into RESULT.
- DONE:
  - RESULT_VALID=1, STALL=0 for one cycle, so the pipeline advances and captures RESULT.
  - Return to IDLE.
  - A START seen in DONE is not accepted; it is sampled again in IDLE on the next cycle.
- Latency:
  - Normal: acceptance edge E0, CALC E1..E32, FIX E33, DONE on E34. RESULT_VALID is high from E34 to E35, and STALL is high from the request through E34.
  - Fast path: RESULT_VALID is high from E1 to E2.
- RESULT holds its last value outside DONE. RESULT_VALID is low everywhere except DONE.
- FLUSH=1 at an edge in any state: go to IDLE, RESULT_VALID=0, RESULT unchanged. It does not start a new op that edge.
- All arithmetic is modulo 2^XLEN, with 2*XLEN internal width for the product.
- No back-to-back acceptance: a minimum of one IDLE cycle separates operations.

Test Plan:
- MUL: DATA1=7, DATA2=6 → STALL high 35 cycles, RESULT=42 with RESULT_VALID pulse on E34.
- MULH: DATA1=0xFFFFFFFF (-1), DATA2=0xFFFFFFFF (-1) → RESULT=0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU: DATA1=-1, DATA2=2 → 0xFFFFFFFF.
- DIV/REM: DATA1=-7, DATA2=2 → DIV gives 0xFFFFFFFD (-3), REM gives 0xFFFFFFFF (-1). DIVU: DATA1=100, DATA2=7 → 14. REMU with the same operands → 2.
- Divide by zero: DIV and REM with DATA1=5, DATA2=0 → DIV gives 0xFFFFFFFF, REM gives 5, each with RESULT_VALID one cycle after acceptance. Overflow: DIV 0x80000000 / -1 → 0x80000000.
- Abort and reset: assert FLUSH at E10 of a DIV → state returns to IDLE, STALL drops, no RESULT_VALID. Repeat with RESET=0 at E20 → RESULT=0, all outputs low; the next op completes correctly.
- Non-M ops: START=1 with ALU_SIGNAL=6'b010000 (SUB) or 6'b011000 (LUI) → STALL stays 0, no state change.
